// File: rtl/stt8_gfx_pkg.sv
// Shared types and constants for the entity tile renderer: entity word layout, hit-list entry, scan states.
// Latency: n/a (package only).
// Backpressure: n/a.
package stt8_gfx_pkg;

    localparam int ENT_W   = 14;
    localparam int ID_LSB  = 10;
    localparam int ORI_LSB = 8;
    localparam int ROW_LSB = 4;
    localparam int COL_LSB = 0;

    localparam logic [3:0]       ID_UNUSED  = 4'hF;
    localparam logic [ENT_W-1:0] ENT_UNUSED = {ID_UNUSED, 10'd0};

    // Orientation codes: rotation applied when fetching the source texel
    localparam logic [1:0] ORI_0   = 2'b00;
    localparam logic [1:0] ORI_90  = 2'b01;
    localparam logic [1:0] ORI_180 = 2'b10;
    localparam logic [1:0] ORI_270 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // One hit-list entry: everything the pixel stage needs for a slot on the current line
    typedef struct packed {
        logic [3:0] col;
        logic [1:0] ori;
        logic [3:0] id;
        logic       flip;
    } hit_t;

    // Maps display (r, c) within a tile to the sprite source texel {sr, sc}
    function automatic logic [5:0] src_coord(input logic [1:0] ori,
                                             input logic [2:0] r,
                                             input logic [2:0] c);
        logic [5:0] rc;
        case (ori)
            ORI_0:   rc = {r, c};
            ORI_90:  rc = {3'd7 - c, r};
            ORI_180: rc = {3'd7 - r, 3'd7 - c};
            default: rc = {c, 3'd7 - r};
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/entity_sprite_rom.sv
// Sprite glyph ROM: (id, row, col) of an 8x8 sprite to a pixel colour.
// Latency: combinational.
// Backpressure: none.
//
// Ports: id [3:0] sprite ID, r/c [2:0] texel row/col, pixel [COLOUR_W-1:0] texel colour.
// Glyphs: ID1 anti-diagonal plus bottom row, ID2 solid, ID3 checker, IDF blank,
// all others a hollow box. Row bits are stored MSB = column 0.
module entity_sprite_rom
    import stt8_gfx_pkg::*;
#(
    parameter int COLOUR_W = 1
) (
    input  logic [3:0]          id,
    input  logic [2:0]          r,
    input  logic [2:0]          c,
    output logic [COLOUR_W-1:0] pixel
);

    logic [7:0] row_bits;
    logic       bit_on;

    always_comb begin
        row_bits = 8'h00;
        case (id)
            4'h1:      row_bits = (r == 3'd7) ? 8'hFF : (8'h01 << r);
            4'h2:      row_bits = 8'hFF;
            4'h3:      row_bits = r[0] ? 8'h55 : 8'hAA;
            ID_UNUSED: row_bits = 8'h00;
            default:   row_bits = (r == 3'd0 || r == 3'd7) ? 8'hFF : 8'h81;
        endcase
        bit_on = row_bits[3'd7 - c];
        pixel  = {COLOUR_W{bit_on}};
    end

endmodule

// File: rtl/entity_tile_renderer.sv
// Entity tile renderer: double-buffered entity table, per-line hit-list scan and a pixel pipe to colour.
// Latency: colour is 3 cycles after counter_H/counter_V.
// Backpressure: none; writes always accepted, overflowing hits are dropped and flagged.
//
// Ports:
//   clk, reset                      pixel clock, synchronous active-high reset
//   ent_wr_en/ent_wr_idx/ent_wr_data write one pending slot (idx >= NUM_ENT ignored)
//   counter_H, counter_V            VGA pixel/line counters
//   colour                          registered pixel colour
//   hit_overflow                    sticky per frame: a line had more than MAX_HITS hits
//   scan_busy                       hit-list scan running
module entity_tile_renderer
    import stt8_gfx_pkg::*;
#(
    parameter int                 NUM_ENT    = 9,
    parameter int                 MAX_HITS   = 4,
    parameter int                 TILE_SHIFT = 5,
    parameter int                 H_ACTIVE   = 640,
    parameter int                 V_ACTIVE   = 480,
    parameter int                 V_TOTAL    = 525,
    parameter int                 COLOUR_W   = 1,
    parameter logic [NUM_ENT-1:0] FLIP_MASK  = 9'h180
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ent_wr_en,
    input  logic [$clog2(NUM_ENT)-1:0] ent_wr_idx,
    input  logic [ENT_W-1:0]           ent_wr_data,
    input  logic [9:0]                 counter_H,
    input  logic [9:0]                 counter_V,
    output logic [COLOUR_W-1:0]        colour,
    output logic                       hit_overflow,
    output logic                       scan_busy
);

    localparam int IDX_W = $clog2(NUM_ENT);
    localparam int CNT_W = $clog2(MAX_HITS + 1);

    // ------------------------------------------------------------------
    // Entity tables: game logic writes pending, the display reads active
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] pending [NUM_ENT];
    logic [ENT_W-1:0] active  [NUM_ENT];
    logic             frame_start;

    assign frame_start = (counter_H == 10'd0) && (counter_V == 10'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                pending[i] <= ENT_UNUSED;
                active[i]  <= ENT_UNUSED;
            end
        end else begin
            if (ent_wr_en && (int'(ent_wr_idx) < NUM_ENT)) begin
                pending[ent_wr_idx] <= ent_wr_data;
            end
            // Copies the pre-edge pending table, so a same-cycle write waits a frame
            if (frame_start) begin
                for (int i = 0; i < NUM_ENT; i++) begin
                    active[i] <= pending[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: during horizontal blanking, collect the slots on the next line
    // ------------------------------------------------------------------
    scan_state_t      state, state_nxt;
    logic             scan_start;
    logic             list_swap;
    logic [IDX_W-1:0] scan_idx;
    logic [9:0]       scan_row;
    logic [9:0]       next_line;
    logic [ENT_W-1:0] scan_ent;
    logic             slot_hit;

    hit_t             build_list [MAX_HITS];
    logic [CNT_W-1:0] build_cnt;
    hit_t             live_list  [MAX_HITS];
    logic [CNT_W-1:0] live_cnt;
    logic [9:0]       live_row;

    assign next_line = (counter_V == 10'(V_TOTAL - 1)) ? 10'd0 : counter_V + 10'd1;
    assign scan_ent  = active[scan_idx];
    assign slot_hit  = (state == ST_SCAN)
                    && (scan_ent[ID_LSB +: 4] != ID_UNUSED)
                    && ({6'd0, scan_ent[ROW_LSB +: 4]} == scan_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        scan_start = 1'b0;
        list_swap  = 1'b0;
        scan_busy  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (counter_H == 10'(H_ACTIVE)) begin
                    state_nxt  = ST_SCAN;
                    scan_start = 1'b1;
                end
            end
            ST_SCAN: begin
                scan_busy = 1'b1;
                if (scan_idx == IDX_W'(NUM_ENT - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                list_swap = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx     <= '0;
            scan_row     <= '0;
            build_cnt    <= '0;
            live_cnt     <= '0;
            live_row     <= '0;
            hit_overflow <= 1'b0;
            for (int k = 0; k < MAX_HITS; k++) begin
                build_list[k] <= '0;
                live_list[k]  <= '0;
            end
        end else begin
            if (scan_start) begin
                scan_idx  <= '0;
                build_cnt <= '0;
                scan_row  <= next_line >> TILE_SHIFT;
            end else if (state == ST_SCAN) begin
                scan_idx <= scan_idx + IDX_W'(1);
            end

            // Ascending slot order keeps list position == priority order
            if (slot_hit && (build_cnt < CNT_W'(MAX_HITS))) begin
                build_list[build_cnt] <= '{col:  scan_ent[COL_LSB +: 4],
                                           ori:  scan_ent[ORI_LSB +: 2],
                                           id:   scan_ent[ID_LSB +: 4],
                                           flip: FLIP_MASK[scan_idx]};
                build_cnt <= build_cnt + CNT_W'(1);
            end

            // live_row tags the list so a pixel from any other row cannot use it
            if (list_swap) begin
                for (int k = 0; k < MAX_HITS; k++) begin
                    live_list[k] <= build_list[k];
                end
                live_cnt <= build_cnt;
                live_row <= scan_row;
            end

            if (frame_start) begin
                hit_overflow <= 1'b0;
            end else if (slot_hit && (build_cnt == CNT_W'(MAX_HITS))) begin
                hit_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipe
    // ------------------------------------------------------------------
    logic [9:0] h_col_full;
    logic       s1_active;
    logic [3:0] s1_col;
    logic [9:0] s1_row;
    logic [2:0] s1_r;
    logic [2:0] s1_c;

    assign h_col_full = counter_H >> TILE_SHIFT;

    // S1: register tile position; in-tile texel bits skip the upscale bits
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_r      <= '0;
            s1_c      <= '0;
        end else begin
            s1_active <= (counter_H < 10'(H_ACTIVE)) && (counter_V < 10'(V_ACTIVE))
                      && (h_col_full < 10'd16);
            s1_col    <= h_col_full[3:0];
            s1_row    <= counter_V >> TILE_SHIFT;
            s1_r      <= counter_V[TILE_SHIFT-1 -: 3];
            s1_c      <= counter_H[TILE_SHIFT-1 -: 3];
        end
    end

    // S2: priority match against the live list, then mirror and rotate
    logic       match;
    hit_t       match_ent;
    logic [2:0] eff_c;
    logic [5:0] src_rc;
    logic       s2_hit;
    logic [3:0] s2_id;
    logic [2:0] s2_sr;
    logic [2:0] s2_sc;

    always_comb begin
        match     = 1'b0;
        match_ent = '0;
        // Descending walk so the lowest matching index is the last assignment
        for (int k = MAX_HITS - 1; k >= 0; k--) begin
            if ((CNT_W'(k) < live_cnt) && (live_list[k].col == s1_col)) begin
                match     = 1'b1;
                match_ent = live_list[k];
            end
        end
        eff_c  = match_ent.flip ? (3'd7 - s1_c) : s1_c;
        src_rc = src_coord(match_ent.ori, s1_r, eff_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_hit <= 1'b0;
            s2_id  <= '0;
            s2_sr  <= '0;
            s2_sc  <= '0;
        end else begin
            s2_hit <= match && s1_active && (live_row == s1_row);
            s2_id  <= match_ent.id;
            s2_sr  <= src_rc[5:3];
            s2_sc  <= src_rc[2:0];
        end
    end

    // S3: ROM lookup and output register
    logic [COLOUR_W-1:0] rom_pixel;

    entity_sprite_rom #(
        .COLOUR_W (COLOUR_W)
    ) u_rom (
        .id    (s2_id),
        .r     (s2_sr),
        .c     (s2_sc),
        .pixel (rom_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            colour <= '0;
        end else begin
            colour <= s2_hit ? rom_pixel : '0;
        end
    end

endmodule
